// File: rtl/mic1_pkg.sv
// Shared MIC-1 memory definitions: strobe bit positions, responder state
// encoding and the in-flight request descriptor.
package mic1_pkg;

    // Bit positions inside the 3-bit mem_ctrl strobe vector.
    localparam int MEM_WRITE = 2;
    localparam int MEM_READ  = 1;
    localparam int MEM_FETCH = 0;

    // IDLE accepts requests; FETCH2 issues a fetch that had to wait for a word op.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        FETCH2 = 1'b1
    } mem_state_t;

    // One request in flight between the RAM address cycle and the result register.
    typedef struct packed {
        logic       is_read;
        logic       is_fetch;
        logic       oor;
        logic [1:0] lane;
    } mem_desc_t;

endpackage

// File: rtl/mic1_mem_ctrl_if.sv
// Core-side memory bus between the MIC-1 datapath (master) and the memory
// responder (slave).
interface mic1_mem_ctrl_if;

    logic [2:0]  mem_ctrl;
    logic [31:0] mar;
    logic [31:0] mdr_wr;
    logic [31:0] pc;
    logic [31:0] mdr_rd;
    logic        mdr_valid;
    logic [7:0]  mbr;
    logic        mbr_valid;
    logic        busy;
    logic        err;

    modport master (
        output mem_ctrl, mar, mdr_wr, pc,
        input  mdr_rd, mdr_valid, mbr, mbr_valid, busy, err
    );

    modport slave (
        input  mem_ctrl, mar, mdr_wr, pc,
        output mdr_rd, mdr_valid, mbr, mbr_valid, busy, err
    );

endinterface

// File: rtl/mic1_byte_select.sv
// Big-endian byte lane extraction: lane 0 is the most significant byte.
module mic1_byte_select (
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    output logic [7:0]  byte_out
);

    // Pick one of the four bytes, MSB first.
    always_comb begin
        byte_out = word[31:24];
        case (lane)
            2'd0: byte_out = word[31:24];
            2'd1: byte_out = word[23:16];
            2'd2: byte_out = word[15:8];
            2'd3: byte_out = word[7:0];
            default: byte_out = word[31:24];
        endcase
    end

endmodule

// File: rtl/mic1_mem_ctrl.sv
// MIC-1 memory responder: services write/read/fetch strobes against a
// single-port synchronous word RAM. Results appear two cycles after the
// request reaches the RAM; a fetch paired with a word op is deferred by one
// cycle (busy) because the RAM has only one port.
module mic1_mem_ctrl
    import mic1_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              resetn,
    mic1_mem_ctrl_if.slave    bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    mem_state_t        state_q;
    logic [ADDR_W+1:0] pc_lat_q;

    logic              idle;
    logic              req_wr;
    logic              req_rd;
    logic              req_fe;
    logic              word_req;
    logic              oor_p0;
    logic              rd_p0;
    logic              fe_p0;
    logic              defer_p0;
    logic              err_set_p0;
    logic [1:0]        lane_p0;

    mem_desc_t         desc_p1;
    logic [7:0]        byte_p1;

    logic [31:0]       mdr_rd_p2;
    logic              mdr_vld_p2;
    logic [7:0]        mbr_p2;
    logic              mbr_vld_p2;
    logic              err_q;

    // High fetch address bits select nothing in a word RAM of this size.
    logic              unused_pc_hi;
    assign unused_pc_hi = ^bus.pc[31:ADDR_W+2];

    // ---- p0: request decode while the address is on the RAM port ----
    // Decode the strobes; a write masks a simultaneous read, and any
    // fetch that shares the cycle with a word op is pushed to FETCH2.
    always_comb begin
        idle       = (state_q == IDLE);
        req_wr     = bus.mem_ctrl[MEM_WRITE];
        req_rd     = bus.mem_ctrl[MEM_READ];
        req_fe     = bus.mem_ctrl[MEM_FETCH];
        word_req   = idle && (req_wr || req_rd);
        oor_p0     = |bus.mar[31:ADDR_W];
        rd_p0      = idle && req_rd && !req_wr;
        fe_p0      = !idle || (req_fe && !req_wr && !req_rd);
        defer_p0   = idle && req_fe && (req_wr || req_rd);
        err_set_p0 = word_req && (oor_p0 || (req_wr && req_rd));
        lane_p0    = idle ? bus.pc[1:0] : pc_lat_q[1:0];
    end

    // Drive the single RAM port: word op first, otherwise the (possibly latched) fetch.
    always_comb begin
        ram_addr  = bus.pc[ADDR_W+1:2];
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (word_req) begin
            ram_addr = bus.mar[ADDR_W-1:0];
            ram_we   = req_wr && !oor_p0;
            if (ram_we) begin
                ram_wdata = bus.mdr_wr;
            end
        end else if (!idle) begin
            ram_addr = pc_lat_q[ADDR_W+1:2];
        end
    end

    // Enter FETCH2 for exactly one cycle when a fetch had to wait.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else if (defer_p0) begin
            state_q <= FETCH2;
        end else begin
            state_q <= IDLE;
        end
    end

    // Hold the byte address of the deferred fetch; the core may move pc afterwards.
    always_ff @(posedge clk) begin
        if (defer_p0) begin
            pc_lat_q <= bus.pc[ADDR_W+1:0];
        end
    end

    // ---- p1: descriptor travels with the RAM read latency ----
    // Only the valid bits are reset, so a reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            desc_p1.is_read  <= 1'b0;
            desc_p1.is_fetch <= 1'b0;
        end else begin
            desc_p1.is_read  <= rd_p0;
            desc_p1.is_fetch <= fe_p0;
        end
        desc_p1.oor  <= rd_p0 && oor_p0;
        desc_p1.lane <= lane_p0;
    end

    mic1_byte_select u_byte_select (
        .word     (ram_rdata),
        .lane     (desc_p1.lane),
        .byte_out (byte_p1)
    );

    // ---- p2: result registers seen by the core ----
    // Capture RAM data into MDR/MBR, pulse the valids, and latch sticky errors.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mdr_rd_p2  <= '0;
            mdr_vld_p2 <= 1'b0;
            mbr_p2     <= '0;
            mbr_vld_p2 <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mdr_vld_p2 <= desc_p1.is_read;
            mbr_vld_p2 <= desc_p1.is_fetch;
            if (desc_p1.is_read) begin
                mdr_rd_p2 <= desc_p1.oor ? 32'd0 : ram_rdata;
            end
            if (desc_p1.is_fetch) begin
                mbr_p2 <= byte_p1;
            end
            if (err_set_p0) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.mdr_rd    = mdr_rd_p2;
    assign bus.mdr_valid = mdr_vld_p2;
    assign bus.mbr       = mbr_p2;
    assign bus.mbr_valid = mbr_vld_p2;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q == FETCH2);

endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// Bench for mic1_mem_ctrl: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level memory model.
module tb_mic1_mem_ctrl;

    localparam int          ADDR_W = 14;
    localparam int          MAXC   = 4096;
    localparam int          NEVER  = 1 << 30;
    localparam logic [31:0] WMASK  = (32'd1 << ADDR_W) - 32'd1;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mic1_mem_ctrl_if bus ();

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    mic1_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Backing RAM: synchronous single port, read data one cycle after the address.
    bit [31:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    // Reference model: memory contents in request order plus expected events per cycle.
    bit [31:0] shadow    [0:(1<<ADDR_W)-1];
    bit        exp_mdr_v [MAXC];
    bit [31:0] exp_mdr   [MAXC];
    bit        exp_mbr_v [MAXC];
    bit [7:0]  exp_mbr   [MAXC];
    bit        exp_busy  [MAXC];
    int        cyc;
    int        err_cyc;
    bit [31:0] held_mdr;
    bit [7:0]  held_mbr;
    int        total;
    int        bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        if (exp_mdr_v[cyc]) held_mdr = exp_mdr[cyc];
        if (exp_mbr_v[cyc]) held_mbr = exp_mbr[cyc];
        chk("mdr_valid", 32'(bus.mdr_valid), 32'(exp_mdr_v[cyc]));
        chk("mdr_rd",    bus.mdr_rd,         held_mdr);
        chk("mbr_valid", 32'(bus.mbr_valid), 32'(exp_mbr_v[cyc]));
        chk("mbr",       32'(bus.mbr),       32'(held_mbr));
        chk("busy",      32'(bus.busy),      32'(exp_busy[cyc]));
        chk("err",       32'(bus.err),       32'(cyc >= err_cyc));
    endtask

    task automatic note_err();
        if (err_cyc > cyc + 1) err_cyc = cyc + 1;
    endtask

    task automatic reset_checks();
        chk("rst_mdr_rd",    bus.mdr_rd,         32'd0);
        chk("rst_mdr_valid", 32'(bus.mdr_valid), 32'd0);
        chk("rst_mbr",       32'(bus.mbr),       32'd0);
        chk("rst_mbr_valid", 32'(bus.mbr_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        chk("rst_ram_addr",  32'(ram_addr),      32'd0);
        chk("rst_ram_we",    32'(ram_we),        32'd0);
        chk("rst_ram_wdata", ram_wdata,          32'd0);
    endtask

    task automatic do_reset();
        check_outputs();
        resetn       = 1'b0;
        bus.mem_ctrl = 3'b000;
        bus.mar      = 32'd0;
        bus.mdr_wr   = 32'd0;
        bus.pc       = 32'd0;
        for (int i = cyc + 1; i < cyc + 5; i++) begin
            exp_mdr_v[i] = 1'b0;
            exp_mbr_v[i] = 1'b0;
            exp_busy[i]  = 1'b0;
        end
        @(posedge clk); #1; cyc++;
        resetn   = 1'b1;
        held_mdr = 32'd0;
        held_mbr = 8'd0;
        err_cyc  = NEVER;
        reset_checks();
    endtask

    // One core request; a word op paired with a fetch is held through the busy cycle.
    task automatic step(input logic [2:0] ctrl, input logic [31:0] mar,
                        input logic [31:0] wdata, input logic [31:0] pc);
        bit        wr, rd, fe, oor, deferred;
        bit [31:0] w;
        int        lat;
        check_outputs();
        bus.mem_ctrl = ctrl;
        bus.mar      = mar;
        bus.mdr_wr   = wdata;
        bus.pc       = pc;
        wr       = ctrl[2];
        rd       = ctrl[1] && !ctrl[2];
        fe       = ctrl[0];
        oor      = (mar >> ADDR_W) != 32'd0;
        deferred = fe && (ctrl[2] || ctrl[1]);
        #1;
        chk("ram_we", 32'(ram_we), 32'(wr && !oor));
        if (ctrl[2] || ctrl[1])
            chk("ram_addr_word", 32'(ram_addr), mar & WMASK);
        else if (fe)
            chk("ram_addr_fetch", 32'(ram_addr), (pc >> 2) & WMASK);
        if (ctrl[2] && ctrl[1]) note_err();
        if ((ctrl[2] || ctrl[1]) && oor) note_err();
        if (wr && !oor) shadow[mar & WMASK] = wdata;
        if (rd) begin
            exp_mdr_v[cyc+2] = 1'b1;
            exp_mdr[cyc+2]   = oor ? 32'd0 : shadow[mar & WMASK];
        end
        if (fe) begin
            lat = deferred ? 3 : 2;
            w   = shadow[(pc >> 2) & WMASK];
            exp_mbr_v[cyc+lat] = 1'b1;
            exp_mbr[cyc+lat]   = 8'(w >> (8 * (3 - pc[1:0])));
        end
        if (deferred) exp_busy[cyc+1] = 1'b1;
        @(posedge clk); #1; cyc++;
        if (deferred) begin
            check_outputs();
            #1;
            chk("ram_we_busy",   32'(ram_we),   32'd0);
            chk("ram_addr_busy", 32'(ram_addr), (pc >> 2) & WMASK);
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(3'b000, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        held_mdr     = 32'd0;
        held_mbr     = 8'd0;
        err_cyc      = NEVER;
        resetn       = 1'b0;
        bus.mem_ctrl = 3'b000;
        bus.mar      = 32'd0;
        bus.mdr_wr   = 32'd0;
        bus.pc       = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc    = 0;
        reset_checks();

        // Write then read-after-write of the same word.
        step(3'b100, 32'h10, 32'hDEADBEEF, 32'd0);
        step(3'b010, 32'h10, 32'd0, 32'd0);
        idle(3);

        // Fetch all four lanes of one word on consecutive cycles.
        step(3'b100, 32'h4, 32'h11223344, 32'd0);
        for (int i = 0; i < 4; i++) step(3'b001, 32'd0, 32'd0, 32'h10 + 32'(i));
        idle(3);

        // Write + fetch of the same word: fetch sees the new data.
        step(3'b101, 32'h5, 32'hAABBCCDD, 32'h15);
        idle(4);

        // Read + fetch of one word, then back-to-back reads.
        step(3'b011, 32'h4, 32'd0, 32'h12);
        step(3'b010, 32'h10, 32'd0, 32'd0);
        step(3'b010, 32'h5, 32'd0, 32'd0);
        step(3'b010, 32'h4, 32'd0, 32'd0);
        idle(3);

        // Write and read together: write wins, no read result, error.
        do_reset();
        step(3'b110, 32'h20, 32'h12345678, 32'd0);
        idle(2);
        step(3'b010, 32'h20, 32'd0, 32'd0);
        idle(3);

        // Out-of-range read and write.
        do_reset();
        step(3'b010, 32'h0001_0000, 32'd0, 32'd0);
        idle(3);
        step(3'b100, 32'h8000_0005, 32'h0BADF00D, 32'd0);
        step(3'b010, 32'h5, 32'd0, 32'd0);
        idle(3);

        // Reset while a read and a deferred fetch are in flight.
        do_reset();
        check_outputs();
        bus.mem_ctrl = 3'b011;
        bus.mar      = 32'h10;
        bus.pc       = 32'h10;
        exp_busy[cyc+1] = 1'b1;
        @(posedge clk); #1; cyc++;
        do_reset();
        idle(4);

        // Random traffic over a small address window.
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  c;
            logic [31:0] a;
            logic [31:0] p;
            logic [31:0] d;
            c = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0)
                a = (32'h0001_0000 << $urandom_range(0, 15)) | 32'($urandom_range(0, 31));
            else
                a = 32'($urandom_range(0, 31));
            p = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) p = p | 32'hFFFF_0000;
            d = $urandom;
            step(c, a, d, p);
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mic1_mem_ctrl.md
# mic1_mem_ctrl

Memory responder for the MIC-1 datapath. It accepts the microinstruction memory strobes (write, read, fetch) with the MAR, MDR and PC values, and services them against a single-port synchronous word RAM. It returns 32-bit words for MDR and big-endian bytes for MBR with a fixed, documented latency. It sits between the `mic1` core and the backing RAM and serializes the one case the single RAM port cannot serve in one cycle: a word access and a fetch in the same cycle.

## Interface
- `ADDR_W`, 14: word-address width of the backing RAM, giving 2^ADDR_W words.
- `clk` in 1: clock; all state changes on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `mem_ctrl` in 3: `[2]` write, `[1]` read, `[0]` fetch. Sampled only when `busy`=0.
- `mar` in 32: word address for read/write.
- `mdr_wr` in 32: write data.
- `pc` in 32: byte address for fetch.
- `mdr_rd` out 32: read data; holds its value until the next read completes.
- `mdr_valid` out 1: one-cycle pulse when `mdr_rd` updates.
- `mbr` out 8: fetched byte; holds its value until the next fetch completes.
- `mbr_valid` out 1: one-cycle pulse when `mbr` updates.
- `busy` out 1: `mem_ctrl` is not accepted this cycle.
- `err` out 1: sticky error flag, cleared only by reset.
- `ram_addr` out ADDR_W: RAM word address.
- `ram_we` out 1: RAM write enable.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid one cycle after its address is presented.

## Operation
- **States:**
  - IDLE: accepts a request.
  - FETCH2: issues a deferred fetch.
  - `busy` = (state == FETCH2). Moore output.
- **Accept:** a request is accepted in cycle T if state is IDLE and `mem_ctrl` != 0.
- **RAM port in IDLE:** driven combinationally from the inputs.
  - Word op present: `ram_addr` = `mar[ADDR_W-1:0]`, `ram_we` = write.
  - Otherwise: `ram_addr` = `pc[ADDR_W+1:2]`.
- **Word op and fetch together:** the word op goes to RAM at T. `pc[ADDR_W+1:0]` is latched and the state moves to FETCH2. In FETCH2 the latched fetch is issued, then the state returns to IDLE.
- **Write and read both set:** the write wins, the read is dropped, and `err` is set.
- **Out of range:** for any word op with `mar[31:ADDR_W]` != 0:
  - a write is suppressed (`ram_we`=0);
  - a read completes with `mdr_rd` = 0;
  - `err` is set.
  - Fetch addresses ignore `pc[31:ADDR_W+2]`; this is not an error.
- **Byte select:** big-endian. Lane `pc[1:0]`=0 → `ram_rdata[31:24]`, 1 → `[23:16]`, 2 → `[15:8]`, 3 → `[7:0]`. The lane is carried in the pipeline alongside the request.
- **Write + fetch of the same word:** the write is issued first, so the fetch returns the new data.
- **Read + fetch of the same word:** both return data from the same RAM contents.
- **Requests while busy:** not accepted, not flagged. The core holds `mem_ctrl` for the busy cycle.
- **Reset values:** all outputs 0, state IDLE. Any in-flight result is discarded: no valid pulse follows reset, even if the request was issued before it.

## Timing
- **Read accepted at T:**
  - RAM address at T;
  - data captured at the edge ending T+1;
  - `mdr_valid`=1 and new `mdr_rd` during T+2.
- **Fetch accepted alone at T:** `mbr_valid` during T+2.
- **Word op + fetch at T:**
  - `busy`=1 during T+1;
  - word result (if a read) during T+2;
  - `mbr_valid` during T+3.
- **Write at T:** `ram_we`=1 during T only. A read of the same address accepted at T+1 returns the new data.
- **Throughput:** one accepted request per cycle. Back-to-back reads give back-to-back `mdr_valid` pulses.

## Structure
- Package `mic1_pkg` holds:
  - localparams `MEM_WRITE`=2, `MEM_READ`=1, `MEM_FETCH`=0 (bit indices);
  - enum `mem_state_t` {IDLE, FETCH2}.
  - `mic1` reuses these when it decodes MIR.
- Sub-module `mic1_byte_select`: combinational 32→8 big-endian lane mux (`word`, `lane`, `byte_out`).
- Pipeline registers: a one-deep in-flight descriptor with fields {is_read, is_fetch, oor, lane}. These separately cover the word op and the fetch.

## Test plan
1. Write `mar`=0x10, data 0xDEADBEEF at T; read `mar`=0x10 at T+1 → `mdr_valid` at T+3, `mdr_rd`=0xDEADBEEF, `err`=0.
2. RAM word 4 = 0x11223344; fetch `pc`=0x10..0x13 on consecutive cycles → `mbr` = 0x11, 0x22, 0x33, 0x44, with `mbr_valid` each cycle starting at T+2.
3. Write `mar`=5, data 0xAABBCCDD with fetch `pc`=0x15 at T → `busy`=1 at T+1, `mbr`=0xBB at T+3.
4. Read `mar`=0x0001_0000 with `ADDR_W`=14 → `mdr_rd`=0 at T+2, `err`=1 sticky; a later write to an out-of-range address leaves RAM unchanged.
5. `mem_ctrl`=3'b110 at T → write performed, no `mdr_valid`, `err`=1.
6. Read + fetch at T, `resetn`=0 at T+1 → no `mdr_valid` or `mbr_valid` afterwards, `busy`=0, all outputs 0 after the reset edge.
